// File: rtl/dbus_arbiter_2m_if.sv
// dbus_arbiter_2m_if: one requester port of the two-master data-bus arbiter.
// The master drives the access request; the arbiter returns grant and read data.
interface dbus_arbiter_2m_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output req, addr, wdata, we,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, addr, wdata, we,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/dbus_arbiter_2m.sv
// dbus_arbiter_2m: two-master data-bus arbiter with registered slave bus.
// Define DBUS_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module dbus_arbiter_2m #(
  parameter logic [31:0] PER_BASE  = 32'h0000_0400,
  parameter logic [31:0] PER_LIMIT = 32'h0000_04FF,
  parameter int unsigned MAX_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  dbus_arbiter_2m_if.slave  m0,
  dbus_arbiter_2m_if.slave  m1,
  output logic [31:0]       addr_per,
  output logic [31:0]       wdata_per,
  output logic [3:0]        we_per,
  output logic [1:0]        ce,
  input  logic [31:0]       rdata_per
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t      st;
  state_t      st_nx;
  logic        last_win;
  logic        last_win_nx;
  logic [3:0]  hold_cnt;
  logic [3:0]  hold_nx;
  logic        rr1;
  logic        pick1;
  logic        other_req;
  logic        regrant;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_we;
  logic [1:0]  sel_ce;
  logic        rd_done;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        rvalid0_q;
  logic        rvalid1_q;

  // contention winner: owner may keep the bus for a bounded run
  always_comb begin
    rr1 = ~last_win;
`ifdef DBUS_FIXED_PRIO_EN
    rr1 = 1'b0;
`else
    if (st == ACC0 && hold_cnt < HOLD_LIM)
      rr1 = 1'b0;
    else if (st == ACC1 && hold_cnt < HOLD_LIM)
      rr1 = 1'b1;
`endif
  end

  // next owner of the slave bus from the live request lines
  always_comb begin
    st_nx = IDLE;
    pick1 = 1'b0;
    unique case (1'b1)
      (!m0.req && !m1.req): begin
        st_nx = IDLE;
      end
      (m0.req && !m1.req): begin
        st_nx = ACC0;
      end
      (!m0.req && m1.req): begin
        st_nx = ACC1;
        pick1 = 1'b1;
      end
      (m0.req && m1.req): begin
        pick1 = rr1;
        st_nx = rr1 ? ACC1 : ACC0;
      end
      default: begin
        st_nx = IDLE;
      end
    endcase
  end

  // winner history and consecutive-regrant run length
  always_comb begin
    last_win_nx = last_win;
    hold_nx     = 4'd0;
    other_req   = pick1 ? m0.req : m1.req;
    regrant     = (st == ACC0 && st_nx == ACC0) ||
                  (st == ACC1 && st_nx == ACC1);
    if (st_nx != IDLE)
      last_win_nx = pick1;
    if (regrant && other_req) begin
      if (hold_cnt >= HOLD_LIM)
        hold_nx = hold_cnt;
      else
        hold_nx = hold_cnt + 4'd1;
    end
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      last_win <= 1'b1;
      hold_cnt <= 4'd0;
    end else begin
      st       <= st_nx;
      last_win <= last_win_nx;
      hold_cnt <= hold_nx;
    end
  end

  // winning master's access and its address decode
  always_comb begin
    sel_addr  = pick1 ? m1.addr  : m0.addr;
    sel_wdata = pick1 ? m1.wdata : m0.wdata;
    sel_we    = pick1 ? m1.we    : m0.we;
    if (sel_addr >= PER_BASE && sel_addr <= PER_LIMIT)
      sel_ce = 2'b10;
    else
      sel_ce = 2'b01;
  end

  // slave bus: address/data hold when idle, strobes drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_per  <= 32'h0;
      wdata_per <= 32'h0;
      we_per    <= 4'h0;
      ce        <= 2'b00;
    end else if (st_nx == IDLE) begin
      we_per    <= 4'h0;
      ce        <= 2'b00;
    end else begin
      addr_per  <= sel_addr;
      wdata_per <= sel_wdata;
      we_per    <= sel_we;
      ce        <= sel_ce;
    end
  end

  assign rd_done = (we_per == 4'h0);

  // read return: capture slave data at the end of a read access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= (st == ACC0) && rd_done;
      rvalid1_q <= (st == ACC1) && rd_done;
      if (st == ACC0 && rd_done)
        rdata0_q <= rdata_per;
      if (st == ACC1 && rd_done)
        rdata1_q <= rdata_per;
    end
  end

  assign m0.gnt    = (st == ACC0);
  assign m1.gnt    = (st == ACC1);
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;

endmodule
